mem_access_ctrl: RTL and testbench

- Initiator-side load/store controller between the multicycle core and the unified word-addressed instruction/data memory.
- Memory side: combinational word read, synchronous word write.
- Accepts byte/halfword/word load and store requests from the core and drives the memory address, write-data and write-enable.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores, since the memory writes whole words only.

---
 rtl/mem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: core-side load/store unit for a word-wide unified memory.
// Loads are lane-extracted and extended; sub-word stores use read-modify-write.
module mem_access_ctrl #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        MemWrite,
  output logic [31:0] A,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wlow_q, wlow_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        illegal;
  logic        misal;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  always_comb begin
    illegal = 1'b0;
    if (we) begin
      illegal = (funct3 != 3'b000) && (funct3 != 3'b001) &&
                (funct3 != 3'b010);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end
  end

  assign misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  assign rd_byte = RD[{off_q, 3'b000} +: 8];
  assign rd_half = RD[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_ext = {24'h0, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = RD;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the word is preserved.
  always_comb begin
    merged = RD;
    if (funct3_q[0]) begin
      merged[{off_q[1], 4'b0000} +: 16] = wlow_q;
    end else begin
      merged[{off_q, 3'b000} +: 8] = wlow_q[7:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    wlow_d   = wlow_q;
    a_d      = a_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          a_d      = {addr[31:2], 2'b00};
          funct3_d = funct3;
          off_d    = addr[1:0];
          wlow_d   = wdata[15:0];
          err_d    = 1'b0;
          if (illegal || (ERR_ON_MISALIGN && misal)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (!we) begin
            state_d = S_LOAD;
          end else if (funct3[1:0] == 2'b10) begin
            wd_d    = wdata;
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = ld_ext;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        wd_d    = merged;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      wlow_q   <= 16'h0;
      a_q      <= 32'h0;
      wd_q     <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      wlow_q   <= wlow_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done && err_q;
  assign MemWrite = (state_q == S_WRITE) && !reset;
  assign A        = a_q;
  assign WD       = wd_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory model plus byte-lane reference.
// Directed scenarios followed by randomized loads/stores and a reset abort.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        MemWrite;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;

  logic [31:0] mem  [64];
  logic [31:0] refm [64];
  logic        poke;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .MemWrite(MemWrite), .A(A), .WD(WD), .RD(RD)
  );

  assign RD = mem[A[7:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[A[7:2]] <= WD;
    if (poke) mem[poke_idx] <= poke_val;
  end

  // Reference: request outcome straight from the size/sign/alignment rules.
  function automatic logic m_err(logic w, logic [2:0] f, logic [31:0] a);
    bit legal;
    int sz;
    legal = w ? (f <= 3'd2) : !(f == 3'd3 || f == 3'd6 || f == 3'd7);
    sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    return !legal || ((int'(a[1:0]) % sz) != 0);
  endfunction

  function automatic int m_lat(logic w, logic [2:0] f, logic [31:0] a);
    if (m_err(w, f, a)) return 1;
    if (!w || f == 3'd2) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] word, logic [2:0] f,
                                         logic [31:0] a);
    logic [31:0] v;
    int t;
    if (f[1:0] == 2'b00) v = word >> (8 * a[1:0]);
    else if (f[1:0] == 2'b01) v = word >> (16 * a[1]);
    else v = word;
    case (f)
      3'd0: t = $signed(v[7:0]);
      3'd1: t = $signed(v[15:0]);
      3'd4: t = int'(v[7:0]);
      3'd5: t = int'(v[15:0]);
      default: t = int'(v);
    endcase
    return 32'(t);
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] word, logic [2:0] f,
                                          logic [31:0] a, logic [31:0] d);
    logic [31:0] mask;
    logic [31:0] val;
    if (f == 3'd0) begin
      mask = 32'hFF << (8 * a[1:0]);
      val  = (d & 32'hFF) << (8 * a[1:0]);
    end else if (f == 3'd1) begin
      mask = 32'hFFFF << (16 * a[1]);
      val  = (d & 32'hFFFF) << (16 * a[1]);
    end else begin
      mask = 32'hFFFF_FFFF;
      val  = d;
    end
    return (word & ~mask) | (val & mask);
  endfunction

  task automatic poke_word(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke = 1'b1; poke_idx = 6'(idx); poke_val = v;
    @(posedge clk); #1;
    poke = 1'b0;
    refm[idx] = v;
  endtask

  // One request; returns latency in cycles, write pulses and err at done.
  task automatic do_req(input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int wr, output logic e);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    we = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    lat = 99; wr = 0; e = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (MemWrite) wr++;
      if (done) begin
        lat = k; e = err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; poke = 1'b0;
    for (int i = 0; i < 64; i++) poke_word(i, $urandom);
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, MemWrite} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000", {busy, done, err, MemWrite});
    end
    checks++;
    if ({rdata, A, WD} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h A=%h WD=%h exp=0", rdata, A, WD);
    end
    reset = 1'b0;
    exp_rd = 32'h0;
  endtask

  task automatic test_loads();
    logic [2:0]  tf [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] ta [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
    logic [31:0] tr [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899,
                            32'h00008899, 32'h8899AABB};
    int lat, wr;
    logic e;
    poke_word(4, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, tf[i], ta[i], 32'h0, lat, wr, e);
      checks++;
      if ({e, 8'(lat), 8'(wr), rdata} !== {1'b0, 8'd2, 8'd0, tr[i]}) begin
        failures++;
        $display("FAIL load%0d got e=%b lat=%0d wr=%0d rd=%h exp e=0 lat=2 wr=0 rd=%h",
                 i, e, lat, wr, rdata, tr[i]);
      end
    end
    exp_rd = 32'h8899AABB;
  endtask

  task automatic test_stores();
    logic [2:0]  tf [2] = '{3'd0, 3'd1};
    logic [31:0] ta [2] = '{32'h13, 32'h10};
    logic [31:0] td [2] = '{32'h12345655, 32'h0000CAFE};
    logic [31:0] tm [2] = '{32'h5599AABB, 32'h5599CAFE};
    int lat, wr;
    logic e;
    for (int i = 0; i < 2; i++) begin
      do_req(1'b1, tf[i], ta[i], td[i], lat, wr, e);
      refm[4] = tm[i];
      checks++;
      if ({e, 8'(lat), 8'(wr), rdata} !== {1'b0, 8'd3, 8'd1, exp_rd}) begin
        failures++;
        $display("FAIL store%0d got e=%b lat=%0d wr=%0d rd=%h exp e=0 lat=3 wr=1 rd=%h",
                 i, e, lat, wr, rdata, exp_rd);
      end
      checks++;
      if (mem[4] !== tm[i]) begin
        failures++;
        $display("FAIL store%0d_mem got=%h exp=%h", i, mem[4], tm[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        tw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  tf [4] = '{3'd2, 3'd3, 3'd4, 3'd1};
    logic [31:0] ta [4] = '{32'h22, 32'h10, 32'h20, 32'h13};
    int lat, wr;
    logic e;
    for (int i = 0; i < 4; i++) begin
      do_req(tw[i], tf[i], ta[i], 32'hA5A5A5A5, lat, wr, e);
      checks++;
      if ({e, 8'(lat), 8'(wr), rdata} !== {1'b1, 8'd1, 8'd0, exp_rd}) begin
        failures++;
        $display("FAIL err%0d got e=%b lat=%0d wr=%0d rd=%h exp e=1 lat=1 wr=0 rd=%h",
                 i, e, lat, wr, rdata, exp_rd);
      end
      checks++;
      if (mem[ta[i][7:2]] !== refm[ta[i][7:2]]) begin
        failures++;
        $display("FAIL err%0d_mem got=%h exp=%h", i, mem[ta[i][7:2]],
                 refm[ta[i][7:2]]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int dn = 0;
    int wr = 0;
    logic [31:0] exp8;
    exp8 = m_store(refm[8], 3'd0, 32'h21, 32'h77);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h21; wdata = 32'h77;
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      if (done) dn++;
      if (MemWrite) wr++;
      if (k == 1) begin
        req = 1'b1; we = 1'b1; funct3 = 3'd2;
        addr = 32'h30; wdata = 32'hDEADBEEF;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
    refm[8] = exp8;
    checks++;
    if ({8'(dn), 8'(wr)} !== {8'd1, 8'd1}) begin
      failures++;
      $display("FAIL busy_ignore got done=%0d wr=%0d exp done=1 wr=1", dn, wr);
    end
    checks++;
    if ({mem[8], mem[12]} !== {exp8, refm[12]}) begin
      failures++;
      $display("FAIL busy_mem got %h %h exp %h %h", mem[8], mem[12],
               exp8, refm[12]);
    end
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int second = 0;
    int dn = 0;
    logic [31:0] r1, r2;
    r1 = 32'h0; r2 = 32'h0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      if (done) begin
        dn++;
        if (first == 0) begin
          first = k; r1 = rdata; addr = 32'h40;
        end else if (second == 0) begin
          second = k; r2 = rdata; req = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    exp_rd = refm[16];
    checks++;
    if ({8'(dn), 8'(first), 8'(second)} !== {8'd2, 8'd2, 8'd5}) begin
      failures++;
      $display("FAIL b2b_timing got n=%0d t1=%0d t2=%0d exp n=2 t1=2 t2=5",
               dn, first, second);
    end
    checks++;
    if ({r1, r2} !== {refm[4], refm[16]}) begin
      failures++;
      $display("FAIL b2b_data got %h %h exp %h %h", r1, r2, refm[4], refm[16]);
    end
  endtask

  task automatic test_random();
    logic        w, e, ee;
    logic [2:0]  f;
    logic [31:0] a, d;
    int          lat, wr, p, idx;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) f = 3'($urandom_range(0, 7));
      else if (w) f = 3'($urandom_range(0, 2));
      else begin
        p = $urandom_range(0, 4);
        f = (p == 3) ? 3'd4 : (p == 4) ? 3'd5 : 3'(p);
      end
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f[1:0] == 2'b01) a[0] = 1'b0;
      end
      d = $urandom;
      idx = int'(a[7:2]);
      ee = m_err(w, f, a);
      if (!ee && !w) exp_rd = m_load(refm[idx], f, a);
      if (!ee && w) refm[idx] = m_store(refm[idx], f, a, d);
      do_req(w, f, a, d, lat, wr, e);
      checks++;
      if ({e, 8'(lat), 8'(wr)} !== {ee, 8'(m_lat(w, f, a)), 8'(!ee && w)}) begin
        failures++;
        $display("FAIL rnd%0d_ctl w=%b f=%0d a=%h got e=%b lat=%0d wr=%0d exp e=%b lat=%0d",
                 i, w, f, a, e, lat, wr, ee, m_lat(w, f, a));
      end
      checks++;
      if ({rdata, mem[idx]} !== {exp_rd, refm[idx]}) begin
        failures++;
        $display("FAIL rnd%0d_data w=%b f=%0d a=%h got rd=%h mem=%h exp rd=%h mem=%h",
                 i, w, f, a, rdata, mem[idx], exp_rd, refm[idx]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old;
    old = mem[1];
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h04; wdata = 32'h13572468;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_write got MemWrite=%b exp=1", MemWrite);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL rst_gate got MemWrite=%b exp=0", MemWrite);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({busy, done, err, MemWrite, rdata, A, WD} !== 100'h0) begin
      failures++;
      $display("FAIL rst_outputs got ctl=%b rd=%h A=%h WD=%h exp all 0",
               {busy, done, err, MemWrite}, rdata, A, WD);
    end
    checks++;
    if (mem[1] !== old) begin
      failures++;
      $display("FAIL rst_mem got=%h exp=%h", mem[1], old);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
